// File: rtl/riscv_lsu_pkg.sv
// Shared encodings, FSM state type and byte-enable helper for the load/store alignment unit.
package riscv_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_BEAT0,
        LSU_BEAT1,
        LSU_RESP
    } lsu_state_e;

    // Contiguous run of 'bytes' enables starting at lane 'off', clipped to the nb-lane line.
    function automatic logic [7:0] be_mask(input logic [2:0] off, input logic [3:0] bytes,
                                           input int unsigned nb);
        logic [15:0] m;
        m = ((16'd1 << bytes) - 16'd1) << off;
        m = m & ((16'd1 << nb) - 16'd1);
        return m[7:0];
    endfunction

endpackage

// File: rtl/riscv_load_extend.sv
// Sign/zero extension of right-justified load data according to the access size.
module riscv_load_extend #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] line_data,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] rdata
);

    localparam int unsigned IW = $clog2(XLEN);

    int unsigned nbits;
    logic        fill;

    always_comb begin
        rdata = line_data;
        fill  = 1'b0;
        nbits = 32'd8 << size;
        // Sizes as wide as the datapath (or wider) pass through untouched.
        if (nbits < XLEN) begin
            fill = !is_unsigned && line_data[IW'(nbits - 32'd1)];
            for (int i = 0; i < XLEN; i++) begin
                if (unsigned'(i) >= nbits) begin
                    rdata[i] = fill;
                end
            end
        end
    end

endmodule

// File: rtl/riscv_lsu_align.sv
// Load/store alignment unit: word-aligned memory beats, lane shifting, optional two-beat split.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned MISALIGN_SPLIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_fault,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned OFF = $clog2(NB);

    lsu_state_e state_q, state_d;

    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [OFF-1:0]    off_q, off_d;
    logic [4:0]        span_q, span_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic [XLEN-1:0]   merge_q, merge_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [NB-1:0]     mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

    logic [OFF-1:0]    req_off;
    logic [3:0]        req_bytes;
    logic [4:0]        req_span;
    logic              req_fault;
    logic [OFF+2:0]    req_sh;
    logic [OFF+2:0]    off_sh;
    int unsigned       hi_sh;
    logic [7:0]        be0_full, be1_full;
    logic [XLEN-1:0]   be_bits;
    logic [XLEN-1:0]   ext_data;

    assign req_off   = req_addr[OFF-1:0];
    assign req_bytes = 4'd1 << req_size;
    assign req_span  = 5'(req_off) + 5'(req_bytes);
    assign req_fault = (req_size == SZ_D && XLEN == 32) ||
                       (req_span > 5'(NB) && MISALIGN_SPLIT == 0);
    assign req_sh    = {req_off, 3'b000};
    assign off_sh    = {off_q, 3'b000};
    // Second beat carries the bytes that did not fit above lane off in the first line.
    assign hi_sh     = 32'd8 * (NB - 32'(off_q));
    assign be0_full  = be_mask(3'(req_off), req_bytes, NB);
    assign be1_full  = be_mask(3'd0, 4'(span_q - 5'(NB)), NB);

    always_comb begin
        be_bits = '0;
        for (int i = 0; i < int'(NB); i++) begin
            be_bits[8*i +: 8] = {8{mem_be_q[i]}};
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        span_d      = span_q;
        wdata_d     = wdata_q;
        fault_d     = fault_q;
        merge_d     = merge_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_off;
                    span_d  = req_span;
                    wdata_d = req_wdata;
                    fault_d = req_fault;
                    merge_d = '0;
                    if (req_fault) begin
                        state_d = LSU_RESP;
                    end else begin
                        state_d     = LSU_BEAT0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                        mem_be_d    = be0_full[NB-1:0];
                        mem_wdata_d = req_wdata << req_sh;
                    end
                end
            end
            LSU_BEAT0: begin
                if (mem_ack) begin
                    merge_d = mem_rdata >> off_sh;
                    if (span_q > 5'(NB)) begin
                        state_d     = LSU_BEAT1;
                        mem_addr_d  = mem_addr_q + ADDR_W'(NB);
                        mem_be_d    = be1_full[NB-1:0];
                        mem_wdata_d = wdata_q >> hi_sh;
                    end else begin
                        state_d     = LSU_RESP;
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = '0;
                        mem_be_d    = '0;
                        mem_wdata_d = '0;
                    end
                end
            end
            LSU_BEAT1: begin
                if (mem_ack) begin
                    merge_d     = merge_q | ((mem_rdata & be_bits) << hi_sh);
                    state_d     = LSU_RESP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = '0;
                    mem_wdata_d = '0;
                end
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LSU_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            span_q      <= '0;
            wdata_q     <= '0;
            fault_q     <= 1'b0;
            merge_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            span_q      <= span_d;
            wdata_q     <= wdata_d;
            fault_q     <= fault_d;
            merge_q     <= merge_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    riscv_load_extend #(
        .XLEN(XLEN)
    ) u_extend (
        .line_data  (merge_q),
        .size       (size_q),
        .is_unsigned(uns_q),
        .rdata      (ext_data)
    );

    assign req_ready = (state_q == LSU_IDLE);
    assign rsp_valid = (state_q == LSU_RESP);
    assign rsp_fault = rsp_valid && fault_q;
    assign rsp_rdata = (rsp_valid && !we_q && !fault_q) ? ext_data : '0;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_riscv_lsu_align.sv
// Directed bench for riscv_lsu_align: RV32 split, RV32 no-split and RV64 instances.
module tb_riscv_lsu_align;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv, rv_ns, rv64;
    logic        req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [63:0] wdata64;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [63:0] rdata64;

    logic        a_ready, a_valid, a_fault, a_mreq, a_mwe;
    logic [31:0] a_rdata, a_maddr, a_mwdata;
    logic [3:0]  a_mbe;
    logic        n_ready, n_valid, n_fault, n_mreq, n_mwe;
    logic [31:0] n_rdata, n_maddr, n_mwdata;
    logic [3:0]  n_mbe;
    logic        d_ready, d_valid, d_fault, d_mreq, d_mwe;
    logic [63:0] d_rdata, d_mwdata;
    logic [31:0] d_maddr;
    logic [7:0]  d_mbe;

    int n_tests = 0;
    int n_fail  = 0;
    logic n_mem_seen = 1'b0;

    always #5 clk = ~clk;

    riscv_lsu_align #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(rv), .req_ready(a_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(a_valid), .rsp_rdata(a_rdata), .rsp_fault(a_fault),
        .mem_req(a_mreq), .mem_we(a_mwe), .mem_addr(a_maddr), .mem_be(a_mbe),
        .mem_wdata(a_mwdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    riscv_lsu_align #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) u_ns (
        .clk(clk), .rst(rst), .req_valid(rv_ns), .req_ready(n_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(n_valid), .rsp_rdata(n_rdata), .rsp_fault(n_fault),
        .mem_req(n_mreq), .mem_we(n_mwe), .mem_addr(n_maddr), .mem_be(n_mbe),
        .mem_wdata(n_mwdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    riscv_lsu_align #(.XLEN(64), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_d64 (
        .clk(clk), .rst(rst), .req_valid(rv64), .req_ready(d_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(wdata64), .rsp_valid(d_valid), .rsp_rdata(d_rdata), .rsp_fault(d_fault),
        .mem_req(d_mreq), .mem_we(d_mwe), .mem_addr(d_maddr), .mem_be(d_mbe),
        .mem_wdata(d_mwdata), .mem_ack(mem_ack), .mem_rdata(rdata64)
    );

    always @(posedge clk) begin
        if (n_mreq) n_mem_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        rv           = 1'b1;
    endtask

    initial begin
        rv = 0; rv_ns = 0; rv64 = 0; req_we = 0; req_unsigned = 0; req_size = 0;
        req_addr = 0; req_wdata = 0; wdata64 = 0; mem_ack = 1; mem_rdata = 0; rdata64 = 0;

        repeat (3) @(negedge clk);
        chk("rst_ready", a_ready, 1);
        chk("rst_mem_req", a_mreq, 0);
        chk("rst_rsp_valid", a_valid, 0);
        chk("rst_mem_be", a_mbe, 0);
        chk("rst_mem_addr", a_maddr, 0);
        chk("rst_rsp_rdata", a_rdata, 0);
        rst = 0;

        // LB / LBU at 0x103
        @(negedge clk); issue(0, 2'd0, 0, 32'h103, 0); mem_rdata = 32'h80FF1234;
        @(negedge clk); rv = 0;
        chk("lb_mem_req", a_mreq, 1);
        chk("lb_mem_addr", a_maddr, 32'h100);
        chk("lb_mem_be", a_mbe, 4'b1000);
        @(negedge clk);
        chk("lb_rsp_valid", a_valid, 1);
        chk("lb_rdata", a_rdata, 32'hFFFFFF80);
        chk("lb_busy_ready", a_ready, 0);
        @(negedge clk);
        chk("lb_idle_ready", a_ready, 1);
        chk("lb_pulse_end", a_valid, 0);
        issue(0, 2'd0, 1, 32'h103, 0);
        @(negedge clk); rv = 0;
        @(negedge clk);
        chk("lbu_rdata", a_rdata, 32'h00000080);

        // LH at 0x102
        @(negedge clk); issue(0, 2'd1, 0, 32'h102, 0); mem_rdata = 32'hBEEF0000;
        @(negedge clk); rv = 0;
        chk("lh_mem_be", a_mbe, 4'b1100);
        chk("lh_c1_valid", a_valid, 0);
        @(negedge clk);
        chk("lh_c2_valid", a_valid, 1);
        chk("lh_rdata", a_rdata, 32'hFFFFBEEF);

        // Split LW at 0x103
        @(negedge clk); issue(0, 2'd2, 0, 32'h103, 0); mem_rdata = 32'hAA000000;
        @(negedge clk); rv = 0;
        chk("lwsp_b0_addr", a_maddr, 32'h100);
        chk("lwsp_b0_be", a_mbe, 4'b1000);
        @(negedge clk);
        chk("lwsp_b1_addr", a_maddr, 32'h104);
        chk("lwsp_b1_be", a_mbe, 4'b0111);
        chk("lwsp_c2_valid", a_valid, 0);
        mem_rdata = 32'h00DDCCBB;
        @(negedge clk);
        chk("lwsp_c3_valid", a_valid, 1);
        chk("lwsp_rdata", a_rdata, 32'hDDCCBBAA);

        // Split SW at 0x0FE
        @(negedge clk); issue(1, 2'd2, 0, 32'h0FE, 32'h11223344);
        @(negedge clk); rv = 0;
        chk("sw_b0_addr", a_maddr, 32'h0FC);
        chk("sw_b0_be", a_mbe, 4'b1100);
        chk("sw_b0_we", a_mwe, 1);
        chk("sw_b0_wdata", a_mwdata[31:16], 16'h3344);
        @(negedge clk);
        chk("sw_b1_addr", a_maddr, 32'h100);
        chk("sw_b1_be", a_mbe, 4'b0011);
        chk("sw_b1_wdata", a_mwdata[15:0], 16'h1122);
        @(negedge clk);
        chk("sw_rsp_valid", a_valid, 1);
        chk("sw_rdata", a_rdata, 0);
        chk("sw_fault", a_fault, 0);

        // Double on RV32 is illegal
        @(negedge clk); issue(0, 2'd3, 0, 32'h100, 0);
        @(negedge clk); rv = 0;
        chk("ld32_valid", a_valid, 1);
        chk("ld32_fault", a_fault, 1);
        chk("ld32_mem_req", a_mreq, 0);

        // No-split instance: line-crossing LH faults
        @(negedge clk);
        req_we = 0; req_size = 2'd1; req_unsigned = 0; req_addr = 32'h103; rv_ns = 1;
        @(negedge clk); rv_ns = 0;
        chk("ns_valid", n_valid, 1);
        chk("ns_fault", n_fault, 1);
        chk("ns_rdata", n_rdata, 0);
        @(negedge clk);
        chk("ns_mem_never", n_mem_seen, 0);

        // RV64 LW / LWU at 0x4
        req_size = 2'd2; req_unsigned = 0; req_addr = 32'h4; rv64 = 1;
        rdata64 = 64'h80000000_00000000;
        @(negedge clk); rv64 = 0;
        chk("d64_mem_be", d_mbe, 8'hF0);
        chk("d64_mem_addr", d_maddr, 32'h0);
        @(negedge clk);
        chk("d64_lw_valid", d_valid, 1);
        chk("d64_lw_rdata", d_rdata, 64'hFFFFFFFF_80000000);
        @(negedge clk); req_unsigned = 1; rv64 = 1;
        @(negedge clk); rv64 = 0;
        @(negedge clk);
        chk("d64_lwu_rdata", d_rdata, 64'h00000000_80000000);

        // Stall then reset mid-access
        @(negedge clk); mem_ack = 0; issue(0, 2'd2, 0, 32'h100, 0);
        @(negedge clk); rv = 0;
        chk("stall_c1_req", a_mreq, 1);
        chk("stall_c1_addr", a_maddr, 32'h100);
        chk("stall_c1_be", a_mbe, 4'b1111);
        issue(0, 2'd0, 0, 32'h200, 0);
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall_c%0d_req", k), a_mreq, 1);
            chk($sformatf("stall_c%0d_addr", k), a_maddr, 32'h100);
            chk($sformatf("stall_c%0d_be", k), a_mbe, 4'b1111);
            chk($sformatf("stall_c%0d_ready", k), a_ready, 0);
        end
        rst = 1;
        @(negedge clk);
        chk("abort_mem_req", a_mreq, 0);
        chk("abort_ready", a_ready, 1);
        chk("abort_valid", a_valid, 0);
        rv = 0; rst = 0; mem_ack = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("abort_no_rsp%0d", k), a_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
